mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data memory between two requesters: port 0 is the multi-cycle CPU control/datapath (instruction fetch, load, store) and port 1 is the debug/program-loader master. It sequences one access at a time with a valid/ready handshake on both sides, round-robin grants under contention, and a watchdog that terminates hung memory accesses with an error flag. It sits between the CPU memory interface and the memory model/controller.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles m_valid may wait for m_rdy before error termination; must be ≥1, counter width $clog2(TIMEOUT+1)
- clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  one clock; reset is asynchronous and active-high
- r0_valid / r1_valid  in  1  request held high until matching rN_rdy
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  ADDR_W  byte address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_rdy / r1_rdy  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DATA_W  read data, valid in rN_rdy cycle, held until next completion on that port
- r0_err / r1_err  out  1  qualifies rN_rdy: 1 = timed out, rdata undefined-but-held
- m_valid  out  1  memory request
- m_we  out  1  memory write enable, meaningful only with m_valid
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdy  in  1  memory completion, sampled only while m_valid=1
- m_rdata  in  DATA_W  memory read data, valid with m_rdy
- grant  out  1  port currently or last owning memory (0/1)
- busy  out  1  high in ACCESS and RELEASE

## Operation
- States: IDLE, ACCESS, RELEASE.
- IDLE: if any rN_valid, choose winner, latch its we/addr/wdata into m_* registers, set grant, clear watchdog, -> ACCESS. Else stay.
- Arbitration: single requester wins outright; both valid -> port ≠ last_grant wins. last_grant resets to 1 so port 0 wins first contention.
- ACCESS: m_valid=1, m_* stable (registered, not combinational from requester). On m_rdy: capture m_rdata (reads only; writes leave rN_rdata unchanged), pulse rN_rdy with rN_err=0, m_valid=0, -> RELEASE. Watchdog increments each ACCESS cycle without m_rdy; at count == TIMEOUT without m_rdy: pulse rN_rdy with rN_err=1, m_valid=0, -> RELEASE.
- m_rdy on the same cycle the count reaches TIMEOUT: normal completion wins, err=0.
- RELEASE: one dead cycle so requester can drop valid; update last_grant = grant; -> IDLE. A requester still valid in IDLE is treated as a new request.
- Requester dropping rN_valid mid-ACCESS: no abort; access completes, rN_rdy still pulses.
- m_rdy outside ACCESS ignored.
- Reset values: state IDLE, m_valid 0, m_we 0, m_addr 0, m_wdata 0, r0/r1_rdy 0, r0/r1_err 0, r0/r1_rdata 0, grant 0, last_grant 1, busy 0, watchdog 0. Reset mid-ACCESS drops m_valid asynchronously; no completion pulse issued.

## Timing
- Request sampled in IDLE at edge n -> m_valid high from n+1.
- m_rdy sampled at edge k -> rN_rdy/rdata/err visible cycle k+1, m_valid low in k+1.
- Minimum latency rN_valid to rN_rdy: 2 cycles (m_rdy in first ACCESS cycle); issue-to-issue back-to-back: 3 cycles (IDLE, ACCESS, RELEASE).
- Timeout: rN_rdy with err exactly TIMEOUT+1 cycles after m_valid rises.
- Outputs registered; no combinational path from any input to any output.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RELEASE), port ID constants PORT_CPU=0, PORT_DBG=1.
- Sub-module rr_arb2: two request lines + last_grant in, winner + any out; combinational, reused by future bus arbiters.
- Watchdog counter and request latches inline.

## Test plan
- Single read port 0, addr 0x0000_0010, memory returns 0xDEAD_BEEF with m_rdy in 3rd ACCESS cycle -> m_valid 3 cycles, r0_rdy one pulse, r0_rdata 0xDEAD_BEEF, r0_err 0, r1_rdy never.
- Both valid in same cycle after reset, port 0 write 0x4->0x1111_1111, port 1 read 0x8 -> port 0 served first, then port 1; swap order on second contention.
- Port 1 held valid continuously, port 0 requests repeatedly -> strict alternation, no starvation, 3-cycle issue spacing.
- TIMEOUT=4, m_rdy never -> r0_rdy with r0_err=1 exactly 5 cycles after m_valid rise; next request served normally.
- m_rdy coinciding with timeout count -> err=0, data captured.
- sys_rst asserted mid-ACCESS -> m_valid 0 immediately, no rdy pulse, all outputs at reset values, first post-reset contention grants port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding, port identifiers and watchdog sizing helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// With both requests up, the line that did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic any
);

    always_comb begin
        any    = req0 | req1;
        winner = 1'b0;
        unique case (1'b1)
            (req0 && req1):  winner = ~last_grant;
            (req1 && !req0): winner = 1'b1;
            default:         winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sharer for the CPU port and the debug/loader port.
// One access in flight at a time, round-robin under contention, watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rdy,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rdy,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rdy,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              grant,
    output logic              busy
);

    localparam int WD_W = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] TIMEOUT_C = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);

    arb_state_e        state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              busy_q, busy_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              r0_rdy_q, r0_rdy_d;
    logic              r1_rdy_q, r1_rdy_d;
    logic              r0_err_q, r0_err_d;
    logic              r1_err_q, r1_err_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

    logic req_win;
    logic req_any;

    rr_arb2 u_rr_arb2 (
        .req0       (r0_valid),
        .req1       (r1_valid),
        .last_grant (last_grant_q),
        .winner     (req_win),
        .any        (req_any)
    );

    always_comb begin
        state_d      = state_q;
        m_valid_d    = m_valid_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        wd_d         = wd_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        r0_rdy_d     = 1'b0;
        r1_rdy_d     = 1'b0;
        r0_err_d     = 1'b0;
        r1_err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d   = ACCESS;
                    m_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    grant_d   = req_win;
                    wd_d      = '0;
                    if (req_win == PORT_DBG) begin
                        m_we_d    = r1_we;
                        m_addr_d  = r1_addr;
                        m_wdata_d = r1_wdata;
                    end else begin
                        m_we_d    = r0_we;
                        m_addr_d  = r0_addr;
                        m_wdata_d = r0_wdata;
                    end
                end
            end

            // A real completion on the timeout cycle takes precedence.
            ACCESS: begin
                if (m_rdy || wd_q == TIMEOUT_C) begin
                    state_d   = RELEASE;
                    m_valid_d = 1'b0;
                    if (grant_q == PORT_CPU) begin
                        r0_rdy_d = 1'b1;
                        r0_err_d = ~m_rdy;
                        if (m_rdy && !m_we_q) begin
                            r0_rdata_d = m_rdata;
                        end
                    end else begin
                        r1_rdy_d = 1'b1;
                        r1_err_d = ~m_rdy;
                        if (m_rdy && !m_we_q) begin
                            r1_rdata_d = m_rdata;
                        end
                    end
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end

            RELEASE: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                last_grant_d = grant_q;
            end

            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_DBG;
            busy_q       <= 1'b0;
            wd_q         <= '0;
            r0_rdy_q     <= 1'b0;
            r1_rdy_q     <= 1'b0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            wd_q         <= wd_d;
            r0_rdy_q     <= r0_rdy_d;
            r1_rdy_q     <= r1_rdy_d;
            r0_err_q     <= r0_err_d;
            r1_err_q     <= r1_err_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign r0_rdy   = r0_rdy_q;
    assign r1_rdy   = r1_rdy_q;
    assign r0_err   = r0_err_q;
    assign r1_err   = r1_err_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing model plus directed
// scenarios (single read, contention, alternation, timeout, reset).
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;

    logic [1:0]       rv, rwe, rrdy, rerr;
    logic [1:0][31:0] raddr, rwdata, rrdata;
    logic             m_valid, m_we, m_rdy, grant, busy;
    logic [31:0]      m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .r0_valid (rv[0]),
        .r0_we    (rwe[0]),
        .r0_addr  (raddr[0]),
        .r0_wdata (rwdata[0]),
        .r0_rdy   (rrdy[0]),
        .r0_rdata (rrdata[0]),
        .r0_err   (rerr[0]),
        .r1_valid (rv[1]),
        .r1_we    (rwe[1]),
        .r1_addr  (raddr[1]),
        .r1_wdata (rwdata[1]),
        .r1_rdy   (rrdy[1]),
        .r1_rdata (rrdata[1]),
        .r1_err   (rerr[1]),
        .m_valid  (m_valid),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdy    (m_rdy),
        .m_rdata  (m_rdata),
        .grant    (grant),
        .busy     (busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: m_rdy in the rdy_at-th access cycle (0 = never).
    logic [31:0] mem [logic [31:0]];
    int rdy_at = 1;

    initial begin
        int acc;
        acc = 0;
        m_rdy = 1'b0;
        m_rdata = 32'h0;
        mem[32'h10] = 32'hDEAD_BEEF;
        mem[32'h08] = 32'h8888_0008;
        mem[32'h30] = 32'hCAFE_F00D;
        forever begin
            @(negedge clk);
            if (m_valid && !sys_rst) acc++;
            else acc = 0;
            m_rdy = m_valid && !sys_rst && rdy_at != 0 && acc == rdy_at;
            m_rdata = 32'h0BAD_0BAD;
            if (m_rdy) begin
                if (m_we) mem[m_addr] = m_wdata;
                else m_rdata = mem.exists(m_addr) ? mem[m_addr] : ~m_addr;
            end
        end
    end

    // Requesters: hold valid until rdy, then take the next queued request.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t q0[$];
    req_t q1[$];

    initial begin
        req_t r;
        rv = '0;
        rwe = '0;
        raddr = '0;
        rwdata = '0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                rv = '0;
            end else begin
                if (rv[0] && rrdy[0]) rv[0] = 1'b0;
                if (rv[1] && rrdy[1]) rv[1] = 1'b0;
                if (!rv[0] && q0.size() > 0) begin
                    r = q0.pop_front();
                    rv[0] = 1'b1;
                    rwe[0] = r.we;
                    raddr[0] = r.addr;
                    rwdata[0] = r.wdata;
                end
                if (!rv[1] && q1.size() > 0) begin
                    r = q1.pop_front();
                    rv[1] = 1'b1;
                    rwe[1] = r.we;
                    raddr[1] = r.addr;
                    rwdata[1] = r.wdata;
                end
            end
        end
    end

    // Timing model: an access issued at edge i completes at the first
    // later edge with m_rdy, or at edge i+TO+1; the next issue may happen
    // two edges after completion. Contention goes to the other port.
    logic [1:0]       e_rdy = '0;
    logic             e_err = 1'b0;
    logic [1:0][31:0] e_rdata = '0;
    logic             e_mv = 1'b0, e_we = 1'b0, e_grant = 1'b0, e_busy = 1'b0;
    logic [31:0]      e_addr = '0, e_wdata = '0;

    initial begin
        int  mcyc, m_iss, m_done, n;
        bit  m_act, m_last, m_port, fin, p;
        mcyc = 0;
        m_iss = 0;
        m_done = -100;
        m_act = 1'b0;
        m_last = 1'b1;
        m_port = 1'b0;
        forever begin
            @(posedge clk);
            mcyc++;
            if (sys_rst) begin
                m_act = 1'b0;
                m_last = 1'b1;
                m_done = -100;
                e_rdy = '0;
                e_err = 1'b0;
                e_rdata = '0;
                e_mv = 1'b0;
                e_we = 1'b0;
                e_grant = 1'b0;
                e_busy = 1'b0;
                e_addr = '0;
                e_wdata = '0;
            end else begin
                e_rdy = '0;
                if (m_act) begin
                    n = mcyc - m_iss;
                    fin = 1'b0;
                    if (m_rdy) begin
                        fin = 1'b1;
                        e_err = 1'b0;
                        if (!e_we) e_rdata[m_port] = m_rdata;
                    end else if (n == TO + 1) begin
                        fin = 1'b1;
                        e_err = 1'b1;
                    end
                    if (fin) begin
                        m_act = 1'b0;
                        m_done = mcyc;
                        e_rdy[m_port] = 1'b1;
                        m_last = m_port;
                    end
                end else if (mcyc >= m_done + 2 && (rv[0] || rv[1])) begin
                    p = (rv[0] && rv[1]) ? !m_last : rv[1];
                    m_act = 1'b1;
                    m_iss = mcyc;
                    m_port = p;
                    e_grant = p;
                    e_we = rwe[p];
                    e_addr = raddr[p];
                    e_wdata = rwdata[p];
                end
                e_mv = m_act;
                e_busy = m_act || m_done == mcyc;
            end
        end
    end

    // Per-cycle compare plus an event log used by the directed checks.
    int iss_c[$];
    bit iss_g[$];
    int dn_c[$];
    bit dn_p[$];
    bit dn_e[$];

    initial begin
        int   tcyc;
        logic pmv;
        tcyc = 0;
        pmv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcyc++;
            if (sys_rst) begin
                pmv = 1'b0;
            end else begin
                chk("m_valid", 32'(m_valid), 32'(e_mv));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("grant", 32'(grant), 32'(e_grant));
                if (e_mv) begin
                    chk("m_we", 32'(m_we), 32'(e_we));
                    chk("m_addr", m_addr, e_addr);
                    chk("m_wdata", m_wdata, e_wdata);
                end
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("r%0d_rdy", p), 32'(rrdy[p]), 32'(e_rdy[p]));
                    chk($sformatf("r%0d_rdata", p), rrdata[p], e_rdata[p]);
                    if (e_rdy[p])
                        chk($sformatf("r%0d_err", p), 32'(rerr[p]), 32'(e_err));
                end
                if (m_valid && !pmv) begin
                    iss_c.push_back(tcyc);
                    iss_g.push_back(grant);
                end
                if (rrdy != 2'b00) begin
                    dn_c.push_back(tcyc);
                    dn_p.push_back(rrdy[1]);
                    dn_e.push_back(rrdy[1] ? rerr[1] : rerr[0]);
                end
                pmv = m_valid;
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0 && rv == 2'b00 &&
                !busy && !m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: idle not reached within 300 cycles", nm);
        end
    endtask

    initial begin
        int ib, db;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 sys_rst = 1'b0;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rdy", 32'(rrdy), 32'd0);
        chk("rst_r0_rdata", rrdata[0], 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);

        // Contention right after reset: port 0 first, then swap.
        ib = iss_c.size();
        db = dn_c.size();
        rdy_at = 1;
        q0.push_back('{1'b1, 32'h4, 32'h1111_1111});
        q0.push_back('{1'b0, 32'h4, 32'h0});
        q1.push_back('{1'b0, 32'h8, 32'h0});
        wait_idle("contention");
        chk("cont_n", 32'(dn_c.size() - db), 32'd3);
        chk("cont_g0", 32'(iss_g[ib]), 32'd0);
        chk("cont_g1", 32'(iss_g[ib+1]), 32'd1);
        chk("cont_g2", 32'(iss_g[ib+2]), 32'd0);
        chk("cont_gap", 32'(iss_c[ib+1] - iss_c[ib]), 32'd3);
        chk("cont_r0", rrdata[0], 32'h1111_1111);
        chk("cont_r1", rrdata[1], 32'h8888_0008);

        // Port 1 always pending, port 0 repeating: strict alternation.
        ib = iss_c.size();
        for (int i = 0; i < 4; i++)
            q1.push_back('{1'b0, 32'h100 + 32'(4*i), 32'h5555_0000 + 32'(i)});
        for (int i = 0; i < 3; i++)
            q0.push_back('{1'b0, 32'h200 + 32'(4*i), 32'h6666_0000 + 32'(i)});
        wait_idle("alternate");
        chk("alt_n", 32'(iss_c.size() - ib), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("alt_g%0d", i), 32'(iss_g[ib+i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("alt_gap%0d", i), 32'(iss_c[ib+i+1] - iss_c[ib+i]), 32'd3);
        chk("alt_r0", rrdata[0], 32'hFFFF_FDF7);
        chk("alt_r1", rrdata[1], 32'hFFFF_FEF3);

        // Single read, m_rdy in the third access cycle.
        ib = iss_c.size();
        db = dn_c.size();
        rdy_at = 3;
        q0.push_back('{1'b0, 32'h10, 32'h0});
        wait_idle("single");
        chk("single_n", 32'(dn_c.size() - db), 32'd1);
        chk("single_lat", 32'(dn_c[db] - iss_c[ib]), 32'd3);
        chk("single_port", 32'(dn_p[db]), 32'd0);
        chk("single_err", 32'(dn_e[db]), 32'd0);
        chk("single_r0", rrdata[0], 32'hDEAD_BEEF);
        chk("single_r1", rrdata[1], 32'hFFFF_FEF3);

        // Memory never answers: error completion TO+1 cycles after issue.
        ib = iss_c.size();
        db = dn_c.size();
        rdy_at = 0;
        q0.push_back('{1'b0, 32'h20, 32'h0});
        wait_idle("timeout");
        chk("tmo_n", 32'(dn_c.size() - db), 32'd1);
        chk("tmo_lat", 32'(dn_c[db] - iss_c[ib]), 32'd5);
        chk("tmo_err", 32'(dn_e[db]), 32'd1);
        chk("tmo_hold", rrdata[0], 32'hDEAD_BEEF);
        db = dn_c.size();
        rdy_at = 1;
        q0.push_back('{1'b0, 32'h8, 32'h0});
        wait_idle("after_tmo");
        chk("after_tmo_err", 32'(dn_e[db]), 32'd0);
        chk("after_tmo_r0", rrdata[0], 32'h8888_0008);

        // m_rdy on the very cycle the watchdog reaches TO.
        ib = iss_c.size();
        db = dn_c.size();
        rdy_at = TO + 1;
        q0.push_back('{1'b0, 32'h30, 32'h0});
        wait_idle("coincide");
        chk("coin_lat", 32'(dn_c[db] - iss_c[ib]), 32'd5);
        chk("coin_err", 32'(dn_e[db]), 32'd0);
        chk("coin_r0", rrdata[0], 32'hCAFE_F00D);

        // Reset in the middle of a port 1 access.
        rdy_at = 0;
        q1.push_back('{1'b0, 32'h40, 32'h0});
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_started", 32'(seen), 32'd1);
        @(posedge clk);
        #3 sys_rst = 1'b1;
        #1;
        chk("mid_m_valid", 32'(m_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_rdy", 32'(rrdy), 32'd0);
        chk("mid_r0", rrdata[0], 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 sys_rst = 1'b0;
        ib = iss_c.size();
        db = dn_c.size();
        rdy_at = 1;
        q0.push_back('{1'b0, 32'h10, 32'h0});
        q1.push_back('{1'b0, 32'h8, 32'h0});
        wait_idle("post_rst");
        chk("post_n", 32'(dn_c.size() - db), 32'd2);
        chk("post_g0", 32'(iss_g[ib]), 32'd0);
        chk("post_g1", 32'(iss_g[ib+1]), 32'd1);
        chk("post_r0", rrdata[0], 32'hDEAD_BEEF);
        chk("post_r1", rrdata[1], 32'h8888_0008);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
